wb_master_arb: RTL
==================

// Module: wb_master_arb
// PURPOSE
//  Two-master round-robin Wishbone arbiter with a bus watchdog. Sits in front of the
//  single master port of the shared conbus interconnect (11-bit address, 32-bit data).
//  It grants one master at a time and holds the grant for the whole cyc_i cycle.
//  Any strobe that receives no ack, err or rty within TIMEOUT cycles is terminated
//  with err, so a dead slave cannot hang the bus.
// PARAMETERS
//  DW       32   data width
//  AW       11   address width
//  SW       4    byte-select width (DW/8)
//  TO_W     8    watchdog counter width
//  TIMEOUT  255  cycles of unanswered stb before forced err; 0 disables the watchdog
// PORTS
//  clk_i      in   1    clock, all state on rising edge
//  rst_i      in   1    reset, asynchronous, active-low
//  mN_dat_i   in   DW   master N write data (N=0,1, same for all mN_*)
//  mN_adr_i   in   AW   master N address
//  mN_sel_i   in   SW   master N byte selects
//  mN_we_i    in   1    master N write enable
//  mN_cyc_i   in   1    master N cycle request
//  mN_stb_i   in   1    master N strobe
//  mN_cab_i   in   1    master N burst hint
//  mN_dat_o   out  DW   read data to master N
//  mN_ack_o   out  1    ack to master N
//  mN_err_o   out  1    err to master N
//  mN_rty_o   out  1    rty to master N
//  b_adr_o, b_sel_o, b_dat_o, b_we_o, b_cyc_o, b_stb_o, b_cab_o
//             out  AW/SW/DW/1/1/1/1  to conbus master port
//  b_dat_i, b_ack_i, b_err_i, b_rty_i  in  DW/1/1/1  from conbus master port
//  gnt_o      out  2    one-hot current grant, status only
// BEHAVIOUR
//  - Reset (rst_i=0): state IDLE, gnt_o=0, last=1 so m0 wins first, wd count=0.
//    All b_* outputs are 0 and all mN_ack/err/rty_o are 0, asynchronously.
//  - FSM states: IDLE, GNT0, GNT1. gnt_o is registered and decoded from the state.
//  - IDLE: if only mK_cyc_i is high, go to GNTK. If both are high, grant the master
//    that is not `last`. Arbitration latency is 1 cycle: bus outputs follow the grant
//    on the cycle after the request is sampled.
//  - GNTK: b_* outputs equal mK_* inputs combinationally, and b_stb_o is gated by the
//    watchdog. mK_ack/err/rty_o = b_ack/err/rty_i. mN_dat_o = b_dat_i for both masters.
//    The non-granted master gets ack/err/rty = 0 and simply waits with cyc high.
//  - GNTK -> IDLE when mK_cyc_i=0 and last<=K. There is always one idle turnaround
//    cycle between grants, even when the other master is waiting.
//  - In IDLE all b_* outputs are 0.
//  - Watchdog: the count increments each cycle b_cyc_o & mK_stb_i & !(ack|err|rty).
//    It clears on any termination, when stb is low, and when cyc is low.
//    When count == TIMEOUT-1 and the strobe is still unanswered:
//    mK_err_o=1 for that single cycle, b_stb_o is forced to 0 that cycle, and the
//    count clears.
//  - A slave termination arriving in the same cycle as the timeout is passed through
//    unchanged and no forced err is generated (the termination takes precedence).
//  - Counter saturates; it never wraps.
//  - cyc dropped mid-transfer: the grant is released as normal and the count clears.
//    A late ack from the slave in IDLE is discarded.
//  - Reset asserted mid-transfer: all outputs drop to 0 immediately; the FSM restarts
//    in IDLE with last=1.
// STRUCTURE
//  - Package wb_conbus_pkg: DW/AW/SW constants (shared with the conbus) and the state
//    enum {IDLE, GNT0, GNT1}.
//  - One sub-module, wb_arb_watchdog: counter, compare and force_err/stb_kill outputs,
//    with parameters TO_W and TIMEOUT.
//  - Top level: FSM, round-robin pointer and output muxes.
// TESTING
//  1. Reset, then m0 single read at adr 11'h010. Slave acks in cycle 3 with 32'hDEADBEEF
//     -> gnt_o=01 one cycle after cyc; m0_dat_o=DEADBEEF with m0_ack_o=1; m1 sees no ack.
//  2. m0 and m1 raise cyc in the same cycle after reset -> m0 granted first.
//     m0 drops cyc -> 1 IDLE cycle, then gnt_o=10.
//     Repeat the same stimulus -> m0 granted again (round robin).
//  3. m1 holds cyc for a 4-beat cab burst while m0 requests -> gnt_o stays 10 for all
//     4 acks; m0 granted 2 cycles after m1 drops cyc.
//  4. TIMEOUT=8, slave never answers m0 -> m0_err_o=1 exactly on cycle 8 of the stb;
//     b_stb_o=0 on that cycle; count returns to 0.
//  5. TIMEOUT=8, slave ack on cycle 8 -> ack passed through, m0_err_o stays 0.
//     Separately, TIMEOUT=0 with a 300-cycle stall -> no err generated.
//  6. rst_i pulsed low during an m1 write -> b_cyc_o, b_stb_o and gnt_o go to 0 with no
//     clock edge. After release, a simultaneous request from both masters grants m0.

Source files
------------

// File: rtl/wb_conbus_pkg.sv
// Shared conbus bus geometry and the master arbiter state encoding.
package wb_conbus_pkg;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;
endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts cycles of an unanswered strobe and forces an err
// (killing the strobe) on the TIMEOUT-th cycle. TIMEOUT=0 disables it.
module wb_arb_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cyc,
  input  logic stb,
  input  logic term,
  output logic force_err,
  output logic stb_kill
);
  localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] ONE     = TO_W'(1);

  logic [TO_W-1:0] cnt_r;
  logic [TO_W-1:0] cnt_nxt_s;
  logic            pending_s;
  logic            hit_s;

  // Count compare and saturating next-count; a slave termination beats the timeout
  always_comb begin
    pending_s = cyc & stb & ~term;
    if (TIMEOUT != 0) begin
      hit_s = pending_s & (cnt_r == LIMIT);
    end else begin
      hit_s = 1'b0;
    end
    if (!pending_s || hit_s) begin
      cnt_nxt_s = '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_nxt_s = cnt_r + ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign force_err = hit_s;
  assign stb_kill  = hit_s;
endmodule

// File: rtl/wb_master_arb.sv
// Two-master round-robin Wishbone arbiter in front of the conbus master port.
// The grant is held for a whole cyc; every handover passes through one IDLE cycle.
module wb_master_arb #(
  parameter int DW      = wb_conbus_pkg::DW,
  parameter int AW      = wb_conbus_pkg::AW,
  parameter int SW      = wb_conbus_pkg::SW,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_cab_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_cab_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic [AW-1:0] b_adr_o,
  output logic [SW-1:0] b_sel_o,
  output logic [DW-1:0] b_dat_o,
  output logic          b_we_o,
  output logic          b_cyc_o,
  output logic          b_stb_o,
  output logic          b_cab_o,
  input  logic [DW-1:0] b_dat_i,
  input  logic          b_ack_i,
  input  logic          b_err_i,
  input  logic          b_rty_i,
  output logic [1:0]    gnt_o
);
  import wb_conbus_pkg::*;

  arb_state_e state_r, state_nxt_s;
  logic       last_r, last_nxt_s;
  logic [1:0] gnt_r, gnt_nxt_s;
  logic       sel_cyc_s, sel_stb_s, term_s;
  logic       force_err_s, stb_kill_s;

  // Arbitration: last_r names the master served most recently (1 after reset)
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt_s = last_r ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt_s = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt_s = IDLE;
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = GNT0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt_s = IDLE;
          last_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = GNT1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    case (state_nxt_s)
      GNT0:    gnt_nxt_s = 2'b01;
      GNT1:    gnt_nxt_s = 2'b10;
      default: gnt_nxt_s = 2'b00;
    endcase
  end

  // State, round-robin pointer and grant status registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      gnt_r   <= gnt_nxt_s;
    end
  end

  assign gnt_o  = gnt_r;
  assign term_s = b_ack_i | b_err_i | b_rty_i;

  // Granted master's cyc/stb, kept apart from b_stb_o so the watchdog sees the raw strobe
  always_comb begin
    case (state_r)
      GNT0: begin
        sel_cyc_s = m0_cyc_i;
        sel_stb_s = m0_stb_i;
      end
      GNT1: begin
        sel_cyc_s = m1_cyc_i;
        sel_stb_s = m1_stb_i;
      end
      default: begin
        sel_cyc_s = 1'b0;
        sel_stb_s = 1'b0;
      end
    endcase
  end

  wb_arb_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .cyc       (sel_cyc_s),
    .stb       (sel_stb_s),
    .term      (term_s),
    .force_err (force_err_s),
    .stb_kill  (stb_kill_s)
  );

  // Bus and response muxes; IDLE (and therefore reset) drives everything to zero
  always_comb begin
    b_adr_o  = '0;
    b_sel_o  = '0;
    b_dat_o  = '0;
    b_we_o   = 1'b0;
    b_cyc_o  = 1'b0;
    b_stb_o  = 1'b0;
    b_cab_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state_r)
      GNT0: begin
        b_adr_o  = m0_adr_i;
        b_sel_o  = m0_sel_i;
        b_dat_o  = m0_dat_i;
        b_we_o   = m0_we_i;
        b_cyc_o  = sel_cyc_s;
        b_stb_o  = sel_stb_s & ~stb_kill_s;
        b_cab_o  = m0_cab_i;
        m0_dat_o = b_dat_i;
        m1_dat_o = b_dat_i;
        m0_ack_o = b_ack_i;
        m0_err_o = b_err_i | force_err_s;
        m0_rty_o = b_rty_i;
      end
      GNT1: begin
        b_adr_o  = m1_adr_i;
        b_sel_o  = m1_sel_i;
        b_dat_o  = m1_dat_i;
        b_we_o   = m1_we_i;
        b_cyc_o  = sel_cyc_s;
        b_stb_o  = sel_stb_s & ~stb_kill_s;
        b_cab_o  = m1_cab_i;
        m0_dat_o = b_dat_i;
        m1_dat_o = b_dat_i;
        m1_ack_o = b_ack_i;
        m1_err_o = b_err_i | force_err_s;
        m1_rty_o = b_rty_i;
      end
      default: begin
        b_cyc_o = 1'b0;
      end
    endcase
  end
endmodule
